// File: rtl/vadr_sequencer.sv
// Emits a run of consecutive 4 KiB page virtual addresses, stepping across the
// canonical hole of SV39/SV48 so every emitted address stays canonical.
module vadr_sequencer #(
    parameter int XLEN        = 64,
    parameter int SVMODE_BITS = 4,
    parameter int CNT_BITS    = 20
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [SVMODE_BITS-1:0] SATP_MODE,
    input  logic [XLEN-1:0]        StartVAdr,
    input  logic [CNT_BITS-1:0]    PageCount,
    input  logic                   Start,
    input  logic                   Abort,
    input  logic                   VAdrReady,
    output logic                   VAdrValid,
    output logic [XLEN-1:0]        VAdr,
    output logic                   Busy,
    output logic                   Done,
    output logic                   StartFault,
    output logic [1:0]             dbg_state_o
);

    // Handshake: a page address is transferred on every rising edge where
    // VAdrValid and VAdrReady are both high; VAdr is held while VAdrValid=1 and
    // VAdrReady=0, and VAdrValid never drops without a transfer except on Abort.

    localparam logic [SVMODE_BITS-1:0] MODE_SV39 = SVMODE_BITS'(8);
    localparam logic [SVMODE_BITS-1:0] MODE_SV48 = SVMODE_BITS'(9);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t              state_q;
    logic                sv48_q;
    logic [XLEN-1:0]     vadr_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;
    logic                fault_q;

    logic [XLEN-1:0] aligned_d;
    logic [XLEN-1:0] next_vadr_d;
    logic            canon39_d;
    logic            canon48_d;
    logic            start_ok_d;

    assign aligned_d  = StartVAdr & ~XLEN'(12'hFFF);
    assign canon39_d  = (&StartVAdr[63:38]) | ~(|StartVAdr[63:38]);
    assign canon48_d  = (&StartVAdr[63:47]) | ~(|StartVAdr[63:47]);
    assign start_ok_d = ((SATP_MODE == MODE_SV39) && canon39_d) ||
                        ((SATP_MODE == MODE_SV48) && canon48_d);

    // The top of the lower canonical half jumps to the bottom of the upper half;
    // the all-ones page wraps to zero through the ordinary add.
    always_comb begin
        next_vadr_d = vadr_q + XLEN'(64'h1000);
        if (!sv48_q && vadr_q == XLEN'(64'h0000_003F_FFFF_F000))
            next_vadr_d = XLEN'(64'hFFFF_FFC0_0000_0000);
        else if (sv48_q && vadr_q == XLEN'(64'h0000_7FFF_FFFF_F000))
            next_vadr_d = XLEN'(64'hFFFF_8000_0000_0000);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sv48_q  <= 1'b0;
            vadr_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start && !Abort) begin
                        if (!start_ok_d) begin
                            fault_q <= 1'b1;
                        end else begin
                            sv48_q <= (SATP_MODE == MODE_SV48);
                            vadr_q <= aligned_d;
                            cnt_q  <= PageCount;
                            busy_q <= 1'b1;
                            if (PageCount == '0) begin
                                state_q <= FIN;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= RUN;
                                valid_q <= 1'b1;
                            end
                        end
                    end
                end
                RUN: begin
                    if (Abort) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (VAdrReady) begin
                        if (cnt_q == CNT_BITS'(1)) begin
                            state_q <= FIN;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q  <= cnt_q - CNT_BITS'(1);
                            vadr_q <= next_vadr_d;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign VAdrValid   = valid_q;
    assign VAdr        = vadr_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign StartFault  = fault_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_vadr_sequencer.sv
// Directed and randomized sequences for vadr_sequencer, checked against a
// reference that advances pages by sign-extending from the mode's top VA bit.
module tb_vadr_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  SATP_MODE;
    logic [63:0] StartVAdr;
    logic [19:0] PageCount;
    logic        Start;
    logic        Abort;
    logic        VAdrReady;
    logic        VAdrValid;
    logic [63:0] VAdr;
    logic        Busy;
    logic        Done;
    logic        StartFault;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    vadr_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .SATP_MODE  (SATP_MODE),
        .StartVAdr  (StartVAdr),
        .PageCount  (PageCount),
        .Start      (Start),
        .Abort      (Abort),
        .VAdrReady  (VAdrReady),
        .VAdrValid  (VAdrValid),
        .VAdr       (VAdr),
        .Busy       (Busy),
        .Done       (Done),
        .StartFault (StartFault),
        .dbg_state_o(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Canonical address space viewed as a signed VA of 39 or 48 bits.
    function automatic logic [63:0] sext(input logic [63:0] x, input bit sv48);
        logic signed [63:0] s;
        if (sv48) s = $signed(x << 16) >>> 16;
        else      s = $signed(x << 25) >>> 25;
        return s;
    endfunction

    function automatic logic [63:0] ref_next(input logic [63:0] a, input bit sv48);
        return sext(a + 64'h1000, sv48);
    endfunction

    function automatic bit is_canon(input logic [63:0] a, input bit sv48);
        return sext(a, sv48) == a;
    endfunction

    task automatic check_outputs(input string tag, input bit valid, input bit busy,
                                 input bit done, input bit fault);
        check({tag, "_valid"}, VAdrValid,  valid);
        check({tag, "_busy"},  Busy,       busy);
        check({tag, "_done"},  Done,       done);
        check({tag, "_fault"}, StartFault, fault);
    endtask

    // ready_kind: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
    // abort_after: raise Abort once this many transfers have completed (-1 never).
    task automatic run_seq(input logic [3:0] mode, input logic [63:0] addr,
                           input logic [19:0] cnt, input int ready_kind,
                           input int abort_after, input string tag);
        bit sv48;
        bit ok;
        logic [63:0] a;
        int xfers;
        int cyc;
        bit aborted;
        bit rdy;
        sv48 = (mode == 4'd9);
        ok   = (mode == 4'd8 || mode == 4'd9) && is_canon(addr, sv48);
        exp_q.delete();
        if (ok) begin
            a = {addr[63:12], 12'h000};
            for (int i = 0; i < int'(cnt); i++) begin
                exp_q.push_back(a);
                a = ref_next(a, sv48);
            end
        end

        @(negedge clk);
        SATP_MODE = mode; StartVAdr = addr; PageCount = cnt;
        Start = 1'b1; Abort = 1'b0; VAdrReady = 1'b0;
        @(negedge clk);
        Start = 1'b0;
        SATP_MODE = 4'($urandom_range(0, 15));
        StartVAdr = {$urandom, $urandom};
        PageCount = 20'($urandom_range(0, 7));

        if (!ok) begin
            check_outputs({tag, "_flt"}, 1'b0, 1'b0, 1'b0, 1'b1);
            @(negedge clk);
            check_outputs({tag, "_flt2"}, 1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end
        if (cnt == 20'd0) begin
            check_outputs({tag, "_zero"}, 1'b0, 1'b1, 1'b1, 1'b0);
            @(negedge clk);
            check_outputs({tag, "_zero2"}, 1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end

        xfers = 0; cyc = 0; aborted = 1'b0;
        forever begin
            check_outputs({tag, "_run"}, 1'b1, 1'b1, 1'b0, 1'b0);
            check({tag, "_vadr"}, VAdr, exp_q[0]);
            case (ready_kind)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            Start = ($urandom_range(0, 3) == 0);
            StartVAdr = {$urandom, $urandom};
            if (abort_after >= 0 && xfers == abort_after) begin
                Abort = 1'b1;
                aborted = 1'b1;
            end
            VAdrReady = rdy;
            if (rdy) begin
                void'(exp_q.pop_front());
                xfers++;
            end
            cyc++;
            @(negedge clk);
            Abort = 1'b0; VAdrReady = 1'b0; Start = 1'b0;
            if (aborted) begin
                check_outputs({tag, "_abort"}, 1'b0, 1'b0, 1'b0, 1'b0);
                @(negedge clk);
                check_outputs({tag, "_abort2"}, 1'b0, 1'b0, 1'b0, 1'b0);
                break;
            end
            if (exp_q.size() == 0) begin
                check_outputs({tag, "_fin"}, 1'b0, 1'b1, 1'b1, 1'b0);
                @(negedge clk);
                check_outputs({tag, "_idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
                break;
            end
            if (cyc > 500) begin
                total++;
                bad++;
                $error("FAIL %s_timeout observed=%0d cycles expected=<=500", tag, cyc);
                break;
            end
        end
    endtask

    initial begin
        logic [3:0]  r_mode;
        logic [63:0] r_addr;
        logic [19:0] r_cnt;
        int          r_abort;
        bit          r_sv48;

        reset_n = 1'b0;
        SATP_MODE = 4'd0; StartVAdr = '0; PageCount = '0;
        Start = 1'b0; Abort = 1'b0; VAdrReady = 1'b0;
        #2;
        check_outputs("reset_async", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_vadr", VAdr, 64'h0);
        repeat (2) @(negedge clk);
        check_outputs("reset_clk", 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;

        run_seq(4'd8, 64'h1234, 20'd3, 0, -1, "sv39_basic");
        run_seq(4'd8, 64'h0000_003F_FFFF_E000, 20'd3, 0, -1, "sv39_hole");
        run_seq(4'd9, 64'hFFFF_FFFF_FFFF_F000, 20'd2, 0, -1, "sv48_wrap");
        run_seq(4'd9, 64'h0000_7FFF_FFFF_E000, 20'd3, 0, -1, "sv48_hole");
        run_seq(4'd8, 64'h0000_0040_0000_0000, 20'd3, 0, -1, "sv39_noncanon");
        run_seq(4'd0, 64'h0000_0000_0000_1000, 20'd3, 0, -1, "bare_mode");
        run_seq(4'd8, 64'h0000_0000_0000_5000, 20'd0, 0, -1, "zero_pages");
        run_seq(4'd8, 64'h0000_0000_0001_0000, 20'd4, 1, -1, "stall");
        run_seq(4'd9, 64'h0000_0000_0000_2000, 20'd5, 0, 2, "abort");

        // Abort alone in IDLE, then Start together with Abort.
        @(negedge clk);
        Abort = 1'b1;
        @(negedge clk);
        check_outputs("idle_abort", 1'b0, 1'b0, 1'b0, 1'b0);
        SATP_MODE = 4'd8; StartVAdr = 64'h1000; PageCount = 20'd2; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; Abort = 1'b0;
        check_outputs("start_abort", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-sequence, then a Start on the first edge after release.
        @(negedge clk);
        SATP_MODE = 4'd8; StartVAdr = 64'h4000; PageCount = 20'd5; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0; VAdrReady = 1'b1;
        @(negedge clk);
        @(negedge clk);
        VAdrReady = 1'b0;
        check("rst_mid_vadr", VAdr, 64'h6000);
        check("rst_mid_valid", VAdrValid, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check_outputs("rst_mid_async", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_mid_vadr0", VAdr, 64'h0);
        @(negedge clk);
        check_outputs("rst_mid_held", 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        SATP_MODE = 4'd9; StartVAdr = 64'h9ABC; PageCount = 20'd1; Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        check_outputs("post_rst_run", 1'b1, 1'b1, 1'b0, 1'b0);
        check("post_rst_vadr", VAdr, 64'h9000);
        VAdrReady = 1'b1;
        @(negedge clk);
        VAdrReady = 1'b0;
        check_outputs("post_rst_fin", 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check_outputs("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized sequences biased toward the canonical boundaries.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0:       r_mode = 4'd8;
                1, 2:    r_mode = 4'd9;
                3:       r_mode = 4'd8;
                default: r_mode = 4'($urandom_range(0, 15));
            endcase
            r_sv48 = (r_mode == 4'd9);
            case ($urandom_range(0, 4))
                0: r_addr = 64'h0000_003F_FFFF_F000 - (64'($urandom_range(0, 3)) << 12);
                1: r_addr = 64'h0000_7FFF_FFFF_F000 - (64'($urandom_range(0, 3)) << 12);
                2: r_addr = 64'hFFFF_FFFF_FFFF_F000 - (64'($urandom_range(0, 3)) << 12);
                3: r_addr = sext({$urandom, $urandom}, r_sv48);
                default: r_addr = {$urandom, $urandom};
            endcase
            r_cnt = 20'($urandom_range(0, 6));
            r_abort = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : -1;
            run_seq(r_mode, r_addr, r_cnt, 2, r_abort, "random");
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
